frame_ctrl: RTL and testbench

Frame-level controller for the binary edge-detection pipeline (UART → skid buffer → unpacker → Gx/Gy conv2d → magnitude → output mux → framer → UART). It synchronizes and debounces the mode buttons and applies a new output-mux mode only between frames. It counts accepted input and output pixels to track frame progress, and issues a pipeline flush when the stream stalls mid-frame. It sits beside the datapath: it observes the unpacker-output and framer-input handshakes, and drives the mux select and the flush request.

---
 rtl/frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ctrl.sv
// Frame-level controller: debounced mode select applied between frames, frame progress
// counting on the pipeline handshakes, and a timed flush when the stream stalls mid-frame.
module frame_ctrl #(
  parameter int unsigned ImageWidth     = 320,
  parameter int unsigned ImageHeight    = 240,
  parameter int unsigned KernelWidth    = 3,
  parameter int unsigned DebounceCycles = 250000,
  parameter int unsigned TimeoutCycles  = 2500000,
  parameter int unsigned FlushCycles    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] button_i,
  input  logic       in_valid_i,
  input  logic       in_ready_i,
  input  logic       out_valid_i,
  input  logic       out_ready_i,
  output logic [1:0] mode_o,
  output logic       flush_o,
  output logic       frame_done_o,
  output logic [4:0] led_o
);

  localparam int unsigned InPixels  = ImageWidth * ImageHeight;
  localparam int unsigned OutPixels = (ImageWidth - KernelWidth + 1) *
                                      (ImageHeight - KernelWidth + 1);
  localparam int unsigned InW  = $clog2(InPixels + 1);
  localparam int unsigned OutW = $clog2(OutPixels + 1);
  localparam int unsigned ToW  = $clog2(TimeoutCycles + 1);
  localparam int unsigned FlW  = $clog2(FlushCycles + 1);
  localparam int unsigned DbW  = $clog2(DebounceCycles + 1);
  localparam logic [InW-1:0]  InLast  = InW'(InPixels);
  localparam logic [OutW-1:0] OutLast = OutW'(OutPixels);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TimeoutCycles);
  localparam logic [FlW-1:0]  FlLast  = FlW'(FlushCycles);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DebounceCycles);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StFlush} state_e;

  state_e          state_q, state_d;
  logic [InW-1:0]  in_cnt_q, in_cnt_d;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [FlW-1:0]  fl_cnt_q, fl_cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            flush_q, done_q, done_d;
  logic [4:0]      led_q, led_d;
  logic            toggle_d;

  logic [2:0]      sync1_q, sync2_q;
  logic [1:0]      cand, cand_q, pending_q, pending_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;

  logic in_hs, out_hs;
  assign in_hs  = in_valid_i & in_ready_i;
  assign out_hs = out_valid_i & out_ready_i;

  // Multi-press and release both decode to magnitude mode.
  always_comb begin
    case (sync2_q)
      3'b001:  cand = 2'd1;
      3'b010:  cand = 2'd2;
      3'b100:  cand = 2'd3;
      default: cand = 2'd0;
    endcase
  end

  // db_cnt counts consecutive cycles the current candidate has been seen, this one included.
  always_comb begin
    if (cand != cand_q) begin
      db_cnt_d = DbW'(1);
    end else if (db_cnt_q == DbLast) begin
      db_cnt_d = db_cnt_q;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
    pending_d = (db_cnt_d == DbLast) ? cand : pending_q;
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    to_cnt_d  = '0;
    fl_cnt_d  = '0;
    mode_d    = mode_q;
    done_d    = 1'b0;
    toggle_d  = led_q[4];
    unique case (state_q)
      StIdle: begin
        if (pending_q != mode_q) mode_d = pending_q;
        if (in_hs) begin
          in_cnt_d = InW'(1);
          state_d  = StStream;
        end
      end
      StStream, StDrain: begin
        if (state_q == StStream && in_hs) in_cnt_d = in_cnt_q + InW'(1);
        if (out_hs && out_cnt_q != OutLast) out_cnt_d = out_cnt_q + OutW'(1);
        if (!in_hs && !out_hs) to_cnt_d = to_cnt_q + ToW'(1);
        // in_cnt holds at InLast through DRAIN, so one test covers both states.
        if (to_cnt_d == ToLast) begin
          state_d   = StFlush;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (in_cnt_d == InLast) begin
          if (out_cnt_d == OutLast) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            toggle_d  = ~led_q[4];
            in_cnt_d  = '0;
            out_cnt_d = '0;
            to_cnt_d  = '0;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StFlush: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        fl_cnt_d  = fl_cnt_q + FlW'(1);
        if (fl_cnt_d == FlLast) begin
          fl_cnt_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    led_d = {toggle_d, state_d == StFlush, state_d == StDrain, state_d == StStream,
             state_d == StIdle};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      to_cnt_q  <= '0;
      fl_cnt_q  <= '0;
      mode_q    <= 2'd0;
      flush_q   <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 5'b00001;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      db_cnt_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      to_cnt_q  <= to_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      mode_q    <= mode_d;
      flush_q   <= (state_d == StFlush);
      done_q    <= done_d;
      led_q     <= led_d;
      sync1_q   <= button_i;
      sync2_q   <= sync1_q;
      cand_q    <= cand;
      db_cnt_q  <= db_cnt_d;
      pending_q <= pending_d;
    end
  end

  assign mode_o       = mode_q;
  assign flush_o      = flush_q;
  assign frame_done_o = done_q;
  assign led_o        = led_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Testbench for frame_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic compared every cycle against a frame-level reference model.
module tb_frame_ctrl;

  localparam int W = 6, H = 4, K = 3, Db = 4, To = 20, Fl = 4;
  localparam int InPix  = W * H;
  localparam int OutPix = (W - K + 1) * (H - K + 1);
  localparam logic [4:0] LedIdle = 5'b00001, LedStream = 5'b00010, LedDrain = 5'b00100;
  localparam logic [8:0] RstOuts = {2'd0, 1'b0, 1'b0, LedIdle};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] button = '0;
  logic       in_valid = 1'b0, in_ready = 1'b0, out_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] mode;
  logic       flush, frame_done;
  logic [4:0] led;

  int checks = 0;
  int failures = 0;

  frame_ctrl #(
    .ImageWidth(W), .ImageHeight(H), .KernelWidth(K),
    .DebounceCycles(Db), .TimeoutCycles(To), .FlushCycles(Fl)
  ) dut (
    .clk_i(clk), .rst_i(rst), .button_i(button),
    .in_valid_i(in_valid), .in_ready_i(in_ready),
    .out_valid_i(out_valid), .out_ready_i(out_ready),
    .mode_o(mode), .flush_o(flush), .frame_done_o(frame_done), .led_o(led)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 stream, 2 drain, 3 flush.
  int         m_phase, m_ins, m_outs, m_quiet, m_flush_left;
  logic       m_toggle, m_done;
  logic [1:0] m_mode, m_pend;
  logic [2:0] m_raw[$];
  logic [1:0] m_cand[$];

  function automatic logic [1:0] decode(input logic [2:0] b);
    if (b == 3'b001) return 2'd1;
    if (b == 3'b010) return 2'd2;
    if (b == 3'b100) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [8:0] dut_outs();
    return {mode, flush, frame_done, led};
  endfunction

  function automatic logic [8:0] model_outs();
    return {m_mode, m_phase == 3, m_done, m_toggle, m_phase == 3, m_phase == 2, m_phase == 1,
            m_phase == 0};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ins = 0; m_outs = 0; m_quiet = 0; m_flush_left = 0;
    m_toggle = 1'b0; m_done = 1'b0; m_mode = 2'd0; m_pend = 2'd0;
    m_raw = {3'b000, 3'b000};
    m_cand = {};
  endtask

  task automatic model_step(input logic [2:0] b, input logic ih, input logic oh);
    logic [1:0] c;
    bit stable;
    m_done = 1'b0;
    case (m_phase)
      0: begin
        if (m_pend != m_mode) m_mode = m_pend;
        if (ih) begin m_ins = 1; m_phase = 1; end
      end
      1, 2: begin
        if (m_phase == 1 && ih) m_ins++;
        if (oh && m_outs < OutPix) m_outs++;
        m_quiet = (ih || oh) ? 0 : m_quiet + 1;
        if (m_quiet == To) begin
          m_phase = 3; m_flush_left = Fl; m_ins = 0; m_outs = 0; m_quiet = 0;
        end else if (m_ins == InPix) begin
          if (m_outs == OutPix) begin
            m_done = 1'b1; m_toggle = ~m_toggle; m_ins = 0; m_outs = 0; m_quiet = 0;
            m_phase = 0;
          end else begin
            m_phase = 2;
          end
        end
      end
      default: begin
        m_flush_left--;
        if (m_flush_left == 0) m_phase = 0;
      end
    endcase
    // Button seen by the debouncer is the raw value from two cycles earlier.
    c = decode(m_raw[0]);
    void'(m_raw.pop_front());
    m_raw.push_back(b);
    m_cand.push_back(c);
    if (m_cand.size() > Db) void'(m_cand.pop_front());
    if (m_cand.size() == Db) begin
      stable = 1'b1;
      foreach (m_cand[i]) if (m_cand[i] != m_cand[0]) stable = 1'b0;
      if (stable) m_pend = m_cand[0];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] b, input logic iv, input logic ir, input logic ov,
                       input logic orr);
    @(negedge clk);
    button = b; in_valid = iv; in_ready = ir; out_valid = ov; out_ready = orr;
    @(posedge clk);
    model_step(b, iv & ir, ov & orr);
    #1 check("model", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; button = '0; in_valid = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
    out_ready = 1'b0;
    #1 check("reset_async", 32'(dut_outs()), 32'(RstOuts));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("reset_held", 32'(dut_outs()), 32'(RstOuts));
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    model_step(3'b000, 1'b0, 1'b0);
    #1 check("model", 32'(dut_outs()), 32'(model_outs()));
  endtask

  typedef struct {
    logic [2:0] b;
    logic       ih;
    logic       oh;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vecs(input int n, input logic [2:0] b, input logic ih, input logic oh,
                          input logic [8:0] exp);
    vec_t v;
    v.b = b; v.ih = ih; v.oh = oh; v.exp = exp;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, first_flush, flush_n;
    bit saw_nonzero;
    logic [2:0] picks[6];
    logic [2:0] rb;
    int burst;

    // Debounce: short press ignored, long press applied in IDLE.
    add_vecs(3, 3'b010, 1'b0, 1'b0, {2'd0, 1'b0, 1'b0, LedIdle});
    add_vecs(5, 3'b000, 1'b0, 1'b0, {2'd0, 1'b0, 1'b0, LedIdle});
    add_vecs(6, 3'b010, 1'b0, 1'b0, {2'd0, 1'b0, 1'b0, LedIdle});
    add_vecs(4, 3'b010, 1'b0, 1'b0, {2'd2, 1'b0, 1'b0, LedIdle});
    // Last input and 8th output together, then a stray output in IDLE.
    add_vecs(16, 3'b010, 1'b1, 1'b0, {2'd2, 1'b0, 1'b0, LedStream});
    add_vecs(7, 3'b010, 1'b1, 1'b1, {2'd2, 1'b0, 1'b0, LedStream});
    add_vecs(1, 3'b010, 1'b1, 1'b1, {2'd2, 1'b0, 1'b1, 5'b10001});
    add_vecs(1, 3'b010, 1'b0, 1'b1, {2'd2, 1'b0, 1'b0, 5'b10001});
    add_vecs(2, 3'b010, 1'b0, 1'b0, {2'd2, 1'b0, 1'b0, 5'b10001});

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].b, 1'b1, tbl[i].ih, tbl[i].oh, 1'b1);
      check($sformatf("table[%0d]", i), 32'(dut_outs()), 32'(tbl[i].exp));
    end

    // Normal frame through DRAIN.
    do_reset();
    dones = 0;
    for (int k = 1; k <= InPix; k++) begin
      drive(3'b000, 1'b1, 1'b1, k >= 18, 1'b1);
      if (frame_done) dones++;
    end
    check("normal_no_early_done", 32'(dones), 32'(0));
    check("normal_drain_led", 32'(led), 32'(LedDrain));
    drive(3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("normal_drain_ignores_in", 32'(led), 32'(LedDrain));
    drive(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    check("normal_done", 32'(frame_done), 32'(1));
    check("normal_led_after", 32'(led), 32'(5'b10001));
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("normal_done_one_cycle", 32'(frame_done), 32'(0));

    // Mid-frame press held until the frame completes.
    do_reset();
    saw_nonzero = 1'b0;
    for (int k = 1; k <= InPix; k++) begin
      drive((k > 5) ? 3'b100 : 3'b000, 1'b1, 1'b1, k >= 18, 1'b1);
      if (mode != 2'd0) saw_nonzero = 1'b1;
    end
    drive(3'b100, 1'b0, 1'b0, 1'b1, 1'b1);
    if (mode != 2'd0) saw_nonzero = 1'b1;
    check("press_frame_done", 32'(frame_done), 32'(1));
    check("press_mode_held", 32'(saw_nonzero), 32'(0));
    drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("press_mode_applied", 32'(mode), 32'(3));

    // Stall timeout and flush, then a clean frame.
    do_reset();
    for (int k = 1; k <= 10; k++) drive(3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    first_flush = -1; flush_n = 0;
    for (int q = 1; q <= 30; q++) begin
      drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      if (flush) begin
        flush_n++;
        if (first_flush < 0) first_flush = q;
      end
      if (q == 24) check("stall_idle_led", 32'(led), 32'(LedIdle));
    end
    check("stall_flush_start", 32'(first_flush), 32'(To));
    check("stall_flush_len", 32'(flush_n), 32'(Fl));
    dones = 0;
    for (int k = 1; k <= InPix; k++) begin
      drive(3'b000, 1'b1, 1'b1, k >= 18, 1'b1);
      if (frame_done) dones++;
    end
    drive(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    if (frame_done) dones++;
    check("stall_next_frame", 32'(dones), 32'(1));

    // A handshake on the would-be timeout cycle clears the counter.
    do_reset();
    for (int k = 1; k <= 3; k++) drive(3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    flush_n = 0;
    for (int q = 1; q <= 19; q++) begin
      drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      if (flush) flush_n++;
    end
    drive(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int q = 1; q <= 19; q++) begin
      drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      if (flush) flush_n++;
    end
    check("timeout_hs_wins", 32'(flush_n), 32'(0));
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_after_clear", 32'(flush), 32'(1));

    // Reset during DRAIN with mode 2.
    do_reset();
    for (int k = 1; k <= 10; k++) drive(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_setup_mode", 32'(mode), 32'(2));
    for (int k = 1; k <= InPix; k++) drive(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_setup_drain", 32'(led), 32'(LedDrain));
    do_reset();

    // Randomized traffic against the model.
    picks = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110};
    rb = 3'b000;
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) rb = picks[$urandom_range(0, 5)];
      if (burst == 0 && $urandom_range(0, 119) == 0) burst = int'($urandom_range(17, 23));
      if ($urandom_range(0, 1999) == 0) begin
        do_reset();
      end else if (burst > 0) begin
        burst--;
        drive(rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        drive(rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
